// File: rtl/mycpu_pkg.sv
// mycpu_pkg: bus layouts, load-op indices and exception bit positions shared by the pipeline
package mycpu_pkg;
  localparam int ES_TO_MS_W = 142;
  localparam int MS_TO_WS_W = 136;
  localparam int CANCEL_W = 2;
  localparam int LD_B = 4;
  localparam int LD_BU = 3;
  localparam int LD_H = 2;
  localparam int LD_HU = 1;
  localparam int LD_W = 0;
  localparam int EXC_ALE = 3;
  typedef struct packed {
    logic        ertn;
    logic        csr_we;
    logic        csr_rd;
    logic [31:0] csr_wmask;
    logic [13:0] csr_num;
    logic [16:0] ex_cause;
    logic [4:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;
  typedef struct packed {
    logic        ertn;
    logic        csr_we;
    logic        csr_rd;
    logic [31:0] csr_wmask;
    logic [13:0] csr_num;
    logic [16:0] ex_cause;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half/word of a load response and extends it
module load_align
  import mycpu_pkg::*;
(
  input  logic [4:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  assign value = ld_op[LD_B]  ? {{24{b[7]}}, b} :
                 ld_op[LD_BU] ? {24'b0, b} :
                 ld_op[LD_H]  ? {{16{h[15]}}, h} :
                 ld_op[LD_HU] ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage with response ownership tracking; LOAD_BYPASS_EN lets decode take live load data
module mem_stage
  import mycpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ws_allowin,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  input  logic                  es_mem_req,
  input  logic                  es_req_cancel,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  output logic [4:0]            ms_to_ds_dest,
  output logic [31:0]           ms_to_ds_value,
  output logic                  ms_to_ds_block,
  output logic                  ms_int,
  input  logic                  ws_reflush_ms
);
  es_to_ms_t             es_bus, bus_q;
  logic                  ms_valid_q, req_pending_q, rbuf_valid_q;
  logic [31:0]           rbuf_q, ld_data, ld_value, final_result;
  logic [CANCEL_W-1:0]   cancel_q;
  logic [CANCEL_W:0]     cancel_d;
  logic                  own_ok, ready_go, leave, take;
  assign es_bus = es_to_ms_bus;
  // a response belongs to the resident instruction only once all discards are drained
  assign own_ok = data_sram_data_ok && cancel_q == '0;
  assign ready_go = !req_pending_q || own_ok;
  assign ms_allowin = !ms_valid_q || (ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ready_go && !ws_reflush_ms;
  assign leave = ms_valid_q && ready_go && ws_allowin;
  assign take = own_ok && ms_valid_q && req_pending_q;
  assign cancel_d = {1'b0, cancel_q}
                  + (CANCEL_W+1)'(ws_reflush_ms && ms_valid_q && req_pending_q && !own_ok)
                  + (CANCEL_W+1)'(es_req_cancel)
                  - (CANCEL_W+1)'(data_sram_data_ok && cancel_q != '0);
  assign ld_data = rbuf_valid_q ? rbuf_q : data_sram_rdata;
  load_align u_align (
    .ld_op (bus_q.ld_op),
    .addr  (bus_q.result[1:0]),
    .rdata (ld_data),
    .value (ld_value)
  );
  assign final_result = bus_q.res_from_mem ? ld_value : bus_q.result;
  assign ms_to_ws_bus = {bus_q.ertn, bus_q.csr_we, bus_q.csr_rd, bus_q.csr_wmask, bus_q.csr_num,
                         bus_q.ex_cause, bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
  assign ms_to_ds_dest = (ms_valid_q && bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign ms_to_ds_value = final_result;
`ifdef LOAD_BYPASS_EN
  assign ms_to_ds_block = ms_valid_q && bus_q.res_from_mem && !ready_go;
`else
  assign ms_to_ds_block = ms_valid_q && bus_q.res_from_mem && !rbuf_valid_q;
`endif
  assign ms_int = ms_valid_q && (|bus_q.ex_cause || bus_q.ertn);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      req_pending_q <= 1'b0;
      rbuf_valid_q <= 1'b0;
      rbuf_q <= '0;
      cancel_q <= '0;
      bus_q <= '0;
    end else begin
      cancel_q <= cancel_d[CANCEL_W-1:0];
      if (es_to_ms_valid && ms_allowin) bus_q <= es_bus;
      if (ws_reflush_ms) begin
        ms_valid_q <= 1'b0;
        req_pending_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
        req_pending_q <= es_to_ms_valid && es_mem_req;
      end else if (take) req_pending_q <= 1'b0;
      if (ws_reflush_ms || leave) rbuf_valid_q <= 1'b0;
      else if (take) begin
        rbuf_valid_q <= 1'b1;
        rbuf_q <= data_sram_rdata;
      end
    end
  end
  always_ff @(posedge clk) if (resetn) assert (!cancel_d[CANCEL_W]);
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Accepts the 142-bit execute-to-memory bus and holds one instruction.
- Waits for the data-SRAM response (`data_ok`) of any load or store issued by execute, then aligns and extends load data.
- Forwards the result to writeback, drives bypass/block info to decode, and discards responses belonging to flushed requests.

Parameters:
- ES_TO_MS_W, 142, width of the execute-to-memory bus.
- MS_TO_WS_W, 136, width of the memory-to-writeback bus.
- CANCEL_W, 2, width of the cancelled-response counter (max 3 pending discards).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ws_allowin  in  1  writeback can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute presents an instruction.
- es_to_ms_bus  in  142  {ertn, csr_we, csr_rd, csr_wmask[32], csr_num[14], ex_cause[17], ld_op[5] (b,bu,h,hu,w), res_from_mem, gr_we, dest[5], result[32], pc[32]}, MSB first.
- es_mem_req  in  1  the instruction on the bus has a data-SRAM request accepted (addr_ok seen).
- es_req_cancel  in  1  one-cycle pulse: an accepted request in execute was flushed before entering this stage.
- data_sram_data_ok  in  1  response strobe, one per accepted request, in order.
- data_sram_rdata  in  32  response data.
- ms_to_ws_valid  out  1  instruction ready for writeback.
- ms_to_ws_bus  out  136  {ertn, csr_we, csr_rd, csr_wmask, csr_num, ex_cause, gr_we, dest, final_result, pc}.
- ms_to_ds_dest  out  5  bypass destination; 0 when invalid or gr_we=0.
- ms_to_ds_value  out  32  bypass value (final_result).
- ms_to_ds_block  out  1  valid load whose data is not yet available.
- ms_int  out  1  valid instruction with any ex_cause bit or ertn; execute suppresses store strobes.
- ws_reflush_ms  in  1  flush from writeback.

Behaviour:
- Reset (async, resetn=0):
  - ms_valid=0, req_pending=0, rdata_buf_valid=0, cancel_cnt=0.
  - Hence ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_dest=0, ms_to_ds_block=0, ms_int=0.
- Capture:
  - When es_to_ms_valid && ms_allowin, latch the bus and set req_pending=es_mem_req.
  - ms_valid <= es_to_ms_valid whenever ms_allowin.
- Flush:
  - ws_reflush_ms clears ms_valid next cycle and masks ms_to_ws_valid in the same cycle.
  - Flush overrides capture.
- Cancel counter:
  - Increments on each flush with ms_valid && req_pending && no data_ok this cycle.
  - Increments on each es_req_cancel.
  - Decrements on each data_ok while cancel_cnt!=0.
  - Simultaneous increment and decrement leave it unchanged.
  - Saturation is an assertion failure.
- Response ownership:
  - While cancel_cnt!=0, data_ok is consumed by the counter and never by the resident instruction.
  - Otherwise, data_ok with ms_valid && req_pending clears req_pending and loads rdata_buf, setting rdata_buf_valid.
  - rdata_buf_valid clears when the instruction leaves or is flushed.
- ms_ready_go = !req_pending || (data_ok && cancel_cnt==0).
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !ws_reflush_ms.
- Load data source: rdata_buf if rdata_buf_valid, else live data_sram_rdata.
- Load align, on addr = result[1:0]:
  - ld.b/bu: byte addr, sign/zero extend.
  - ld.h/hu: half at addr[1], sign/zero extend.
  - ld.w: whole word.
- final_result = res_from_mem ? aligned load : result.
- ms_to_ds_block = ms_valid && res_from_mem && !ms_ready_go.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: leaves in the cycle data_ok arrives, or later if ws_allowin=0. Data is then held in rdata_buf.
- Back-to-back: a new instruction may enter in the same cycle the old one leaves.

Optional Feature:
- LOAD_BYPASS_EN:
  - Defined: ms_to_ds_block deasserts in the data_ok cycle and ms_to_ds_value carries the aligned live rdata.
  - Undefined: block stays asserted until rdata_buf_valid, so decode sees registered data only. This costs 1 extra cycle per dependent load.

Decomposition:
- Shared package mycpu_pkg:
  - Bus widths and field offsets for ES_TO_MS and MS_TO_WS.
  - LD_B..LD_W op indices.
  - ex_cause bit index EXC_ALE=3.
- One combinational sub-module load_align: inputs ld_op[5], addr[2], rdata[32]; output value[32].

Test Plan:
- ALU inst (result=0x1234, dest=5, es_mem_req=0), ws_allowin=1 -> ms_to_ws_valid next cycle; final_result=0x1234; ms_to_ds_dest=5.
- ld.b, result[1:0]=2'b11, data_ok 3 cycles later, rdata=0x80FF_0000 -> stall 3 cycles with block=1, then final_result=0xFFFF_FF80. Same with ld.bu -> 0x0000_0080.
- ld.h, addr[1]=1, data_ok with ws_allowin=0 for 2 cycles, rdata=0x7ABC_0001 -> holds; buffered value 0x0000_7ABC delivered when ws_allowin=1.
- Load waiting, ws_reflush_ms pulse, then data_ok with rdata=0xDEAD_BEEF, then new ld.w whose data_ok carries 0x0000_0042 -> first response dropped (cancel_cnt 1->0); new load returns 0x42.
- es_req_cancel pulse plus resident load, then two data_ok -> first discarded, second consumed by the resident load.
- Instruction with ex_cause[3]=1 (ALE), es_mem_req=0 -> ms_int=1, passes without waiting; resetn low mid-wait -> all valids and cancel_cnt cleared immediately.
